// File: rtl/tqv_gpio_pkg.sv
// rtl/tqv_gpio_pkg.sv - register map, select encoding and write-size decode for tqv_gpio_ctrl
package tqv_gpio_pkg;

    localparam logic [3:0] REG_OUT         = 4'd0;
    localparam logic [3:0] REG_IN          = 4'd1;
    localparam logic [3:0] REG_OE          = 4'd2;
    localparam logic [3:0] REG_SEL_LO      = 4'd3;
    localparam logic [3:0] REG_SEL_HI      = 4'd4;
    localparam logic [3:0] REG_IRQ_RISE_EN = 4'd5;
    localparam logic [3:0] REG_IRQ_FALL_EN = 4'd6;
    localparam logic [3:0] REG_IRQ_STATUS  = 4'd7;
    localparam logic [3:0] REG_OUT_SET     = 4'd8;
    localparam logic [3:0] REG_OUT_CLR     = 4'd9;
    localparam logic [3:0] REG_OUT_TGL     = 4'd10;

    localparam logic [3:0] SEL_GPIO      = 4'd0;
    localparam logic [3:0] SEL_FUNC_BASE = 4'd1;

    localparam logic [1:0] WR_BYTE = 2'b00;
    localparam logic [1:0] WR_HALF = 2'b01;
    localparam logic [1:0] WR_WORD = 2'b10;
    localparam logic [1:0] WR_NONE = 2'b11;
    localparam logic [1:0] RD_NONE = 2'b11;

    // Lanes touched by a write; a zero mask makes every merge a no-op.
    function automatic logic [31:0] write_mask(input logic [1:0] write_n);
        case (write_n)
            WR_BYTE: return 32'h0000_00FF;
            WR_HALF: return 32'h0000_FFFF;
            WR_WORD: return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/tqv_gpio_sync_edge.sv
// rtl/tqv_gpio_sync_edge.sv - per-pin input synchroniser with rise/fall detection
module tqv_gpio_sync_edge
    import tqv_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    output logic sync_val,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // prev tracks the last stage even in reset so the first sample after reset
    // is compared against a settled value rather than stale pre-reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
        end
        prev_q <= sync_q[SYNC_STAGES-1];
    end

    assign sync_val = sync_q[SYNC_STAGES-1];
    assign rise     = sync_val & ~prev_q;
    assign fall     = ~sync_val & prev_q;

endmodule

// File: rtl/tqv_gpio_ctrl.sv
// rtl/tqv_gpio_ctrl.sv - tinyQV GPIO register file, pin mux and edge interrupts
module tqv_gpio_ctrl
    import tqv_gpio_pkg::*;
#(
    parameter int NUM_PINS    = 8,
    parameter int NUM_FUNCS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    addr,
    input  logic [1:0]                    write_n,
    input  logic [1:0]                    read_n,
    input  logic [31:0]                   data_in,
    output logic [31:0]                   data_out,
    input  logic [NUM_PINS-1:0]           pin_in,
    output logic [NUM_PINS-1:0]           pin_out,
    output logic [NUM_PINS-1:0]           pin_oe,
    input  logic [NUM_PINS*NUM_FUNCS-1:0] func_out,
    input  logic [NUM_PINS*NUM_FUNCS-1:0] func_oe,
    output logic                          irq
);

    localparam logic [63:0] SEL_VALID = (64'd1 << (4 * NUM_PINS)) - 64'd1;

    logic [NUM_PINS-1:0] out_q, oe_q, rise_en_q, fall_en_q, status_q;
    logic [63:0]         sel_q;
    logic [NUM_PINS-1:0] in_sync, rise, fall, events;
    logic [31:0]         wmask, wdata, rdata;
    logic [NUM_PINS-1:0] wm, wd, stat_clr;

    assign wmask    = write_mask(write_n);
    assign wdata    = data_in & wmask;
    assign wm       = wmask[NUM_PINS-1:0];
    assign wd       = wdata[NUM_PINS-1:0];
    assign stat_clr = (addr == REG_IRQ_STATUS) ? wd : '0;

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        tqv_gpio_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .rst      (rst),
            .pin_in   (pin_in[p]),
            .sync_val (in_sync[p]),
            .rise     (rise[p]),
            .fall     (fall[p])
        );
    end

    assign events = (rise & rise_en_q) | (fall & fall_en_q);
    assign irq    = |status_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            sel_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            // New events are ORed in after the clear so a same-cycle set wins.
            status_q <= (status_q & ~stat_clr) | events;
            case (addr)
                REG_OUT:         out_q     <= (out_q & ~wm) | wd;
                REG_OE:          oe_q      <= (oe_q & ~wm) | wd;
                REG_SEL_LO:      sel_q[31:0]  <= ((sel_q[31:0] & ~wmask) | wdata) & SEL_VALID[31:0];
                REG_SEL_HI:      sel_q[63:32] <= ((sel_q[63:32] & ~wmask) | wdata) & SEL_VALID[63:32];
                REG_IRQ_RISE_EN: rise_en_q <= (rise_en_q & ~wm) | wd;
                REG_IRQ_FALL_EN: fall_en_q <= (fall_en_q & ~wm) | wd;
                REG_OUT_SET:     out_q     <= out_q | wd;
                REG_OUT_CLR:     out_q     <= out_q & ~wd;
                REG_OUT_TGL:     out_q     <= out_q ^ wd;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (addr)
            REG_OUT:         rdata = 32'(out_q);
            REG_IN:          rdata = 32'(in_sync);
            REG_OE:          rdata = 32'(oe_q);
            REG_SEL_LO:      rdata = sel_q[31:0];
            REG_SEL_HI:      rdata = sel_q[63:32];
            REG_IRQ_RISE_EN: rdata = 32'(rise_en_q);
            REG_IRQ_FALL_EN: rdata = 32'(fall_en_q);
            REG_IRQ_STATUS:  rdata = 32'(status_q);
            REG_OUT_SET, REG_OUT_CLR, REG_OUT_TGL: rdata = 32'h0;
            default:         rdata = 32'hFFFF_FFFF;
        endcase
    end

    assign data_out = (read_n != RD_NONE) ? rdata : 32'h0;

    always_comb begin
        pin_out = '0;
        pin_oe  = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            if (sel_q[4*p +: 4] == SEL_GPIO) begin
                pin_out[p] = out_q[p];
                pin_oe[p]  = oe_q[p];
            end
            for (int f = 0; f < NUM_FUNCS; f++) begin
                if (sel_q[4*p +: 4] == SEL_FUNC_BASE + 4'(f)) begin
                    pin_out[p] = func_out[f*NUM_PINS + p];
                    pin_oe[p]  = func_oe[f*NUM_PINS + p];
                end
            end
        end
    end

endmodule

// File: tb/tb_tqv_gpio_ctrl.sv
// tb/tb_tqv_gpio_ctrl.sv - randomized and directed checks of tqv_gpio_ctrl against a behavioural model
module tb_tqv_gpio_ctrl;

    localparam int NP = 8;
    localparam int NF = 4;
    localparam int SS = 2;
    localparam logic [31:0] PIN_M = 32'h0000_00FF;
    localparam logic [63:0] SEL_M = 64'h0000_0000_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        addr = 4'd0;
    logic [1:0]        write_n = 2'b11;
    logic [1:0]        read_n = 2'b11;
    logic [31:0]       data_in = 32'h0;
    logic [31:0]       data_out;
    logic [NP-1:0]     pin_in = '0;
    logic [NP-1:0]     pin_out, pin_oe;
    logic [NP*NF-1:0]  func_out = '0;
    logic [NP*NF-1:0]  func_oe = '0;
    logic              irq;

    always #5 clk = ~clk;

    tqv_gpio_ctrl #(.NUM_PINS(NP), .NUM_FUNCS(NF), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .write_n  (write_n),
        .read_n   (read_n),
        .data_in  (data_in),
        .data_out (data_out),
        .pin_in   (pin_in),
        .pin_out  (pin_out),
        .pin_oe   (pin_oe),
        .func_out (func_out),
        .func_oe  (func_oe),
        .irq      (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit check_on = 1'b0;

    logic [31:0] m_out = 0, m_oe = 0, m_re = 0, m_fe = 0, m_stat = 0, m_in = 0, m_prev = 0;
    logic [63:0] m_sel = 0;
    logic [31:0] m_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: IN is the pin sample taken SS-1 edges ago; edges compare IN before and after.
    always @(posedge clk) begin : model_upd
        logic [31:0] m, d, ev;
        if (rst) begin
            m_out = 0; m_oe = 0; m_re = 0; m_fe = 0; m_stat = 0; m_sel = 0;
            m_prev = m_in;
            m_in = 0;
            m_q = {};
            for (int i = 0; i < SS; i++) m_q.push_back(32'h0);
        end else begin
            ev = ((m_in & ~m_prev & m_re) | (~m_in & m_prev & m_fe)) & PIN_M;
            m = (write_n == 2'b00) ? 32'h0000_00FF :
                (write_n == 2'b01) ? 32'h0000_FFFF :
                (write_n == 2'b10) ? 32'hFFFF_FFFF : 32'h0;
            d = data_in & m;
            case (addr)
                4'd0:  m_out = ((m_out & ~m) | d) & PIN_M;
                4'd2:  m_oe  = ((m_oe & ~m) | d) & PIN_M;
                4'd3:  m_sel[31:0]  = ((m_sel[31:0] & ~m) | d) & SEL_M[31:0];
                4'd4:  m_sel[63:32] = ((m_sel[63:32] & ~m) | d) & SEL_M[63:32];
                4'd5:  m_re  = ((m_re & ~m) | d) & PIN_M;
                4'd6:  m_fe  = ((m_fe & ~m) | d) & PIN_M;
                4'd7:  m_stat = m_stat & ~d;
                4'd8:  m_out = (m_out | d) & PIN_M;
                4'd9:  m_out = m_out & ~d;
                4'd10: m_out = (m_out ^ d) & PIN_M;
                default: ;
            endcase
            m_stat = m_stat | ev;
            m_prev = m_in;
            m_q.push_back(32'(pin_in));
            void'(m_q.pop_front());
            m_in = m_q[0];
        end
    end

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        case (a)
            4'd0: return m_out;
            4'd1: return m_in;
            4'd2: return m_oe;
            4'd3: return m_sel[31:0];
            4'd4: return m_sel[63:32];
            4'd5: return m_re;
            4'd6: return m_fe;
            4'd7: return m_stat;
            4'd8, 4'd9, 4'd10: return 32'h0;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [NP-1:0] exp_pins(input bit want_oe);
        logic [NP-1:0] r = '0;
        int s;
        for (int p = 0; p < NP; p++) begin
            s = int'(m_sel[4*p +: 4]);
            if (s == 0) r[p] = want_oe ? m_oe[p] : m_out[p];
            else if (s <= NF) r[p] = want_oe ? func_oe[(s-1)*NP + p] : func_out[(s-1)*NP + p];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (check_on) begin
            chk("pin_out", 32'(pin_out), 32'(exp_pins(1'b0)));
            chk("pin_oe", 32'(pin_oe), 32'(exp_pins(1'b1)));
            chk("irq", 32'(irq), 32'(m_stat != 0));
            if (read_n != 2'b11) chk("data_out", data_out, exp_read(addr));
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [1:0] sz);
        addr = a; data_in = d; write_n = sz;
        @(posedge clk); #1;
        write_n = 2'b11;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
        addr = a; read_n = 2'b00;
        #1;
        chk(nm, data_out, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_on = 1'b1;
        rst = 1'b0;

        for (int a = 0; a < 16; a++) begin
            rd_chk("reset_read", 4'(a), (a >= 11) ? 32'hFFFF_FFFF : 32'h0);
            @(posedge clk); #1;
        end
        chk("reset_pin_oe", 32'(pin_oe), 32'h0);
        chk("reset_pin_out", 32'(pin_out), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);

        wr(4'd2, 32'hFF, 2'b10);
        wr(4'd0, 32'hA5, 2'b10);
        chk("out_a5", 32'(pin_out), 32'hA5);
        wr(4'd8, 32'h0F, 2'b10);
        chk("out_set", 32'(pin_out), 32'hAF);
        wr(4'd9, 32'h80, 2'b10);
        chk("out_clr", 32'(pin_out), 32'h2F);
        wr(4'd10, 32'h03, 2'b10);
        chk("out_tgl", 32'(pin_out), 32'h2C);

        wr(4'd2, 32'hFFFF_1234, 2'b00);
        rd_chk("oe_byte", 4'd2, 32'h34);
        wr(4'd3, 32'hABCD_0021, 2'b01);
        rd_chk("sel_half", 4'd3, 32'h21);
        func_out = 32'h0000_0201;
        func_oe  = 32'h0000_0001;
        #1;
        chk("mux_out", 32'(pin_out), 32'h2F);
        chk("mux_oe", 32'(pin_oe), 32'h35);
        @(posedge clk); #1;
        wr(4'd3, 32'h2F, 2'b00);
        chk("sel15_out", 32'(pin_out), 32'h2E);
        chk("sel15_oe", 32'(pin_oe), 32'h34);
        wr(4'd3, 32'h0, 2'b10);
        func_out = '0;
        func_oe  = '0;

        wr(4'd5, 32'h01, 2'b10);
        pin_in = 8'h01;
        @(posedge clk); #1;
        rd_chk("in_edge_k", 4'd1, 32'h0);
        @(posedge clk); #1;
        rd_chk("in_edge_k1", 4'd1, 32'h1);
        chk("irq_k1", 32'(irq), 32'h0);
        @(posedge clk); #1;
        chk("irq_k2", 32'(irq), 32'h1);
        rd_chk("stat_k2", 4'd7, 32'h1);
        wr(4'd7, 32'h01, 2'b10);
        chk("irq_w1c", 32'(irq), 32'h0);
        rd_chk("stat_w1c", 4'd7, 32'h0);

        wr(4'd6, 32'h02, 2'b10);
        pin_in = 8'h03;
        repeat (4) @(posedge clk);
        #1;
        chk("irq_no_fall", 32'(irq), 32'h0);
        pin_in = 8'h01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr(4'd7, 32'h02, 2'b10);
        rd_chk("stat_set_wins", 4'd7, 32'h2);
        chk("irq_set_wins", 32'(irq), 32'h1);
        wr(4'd7, 32'h02, 2'b10);
        rd_chk("stat_cleared", 4'd7, 32'h0);

        wr(4'd6, 32'h0, 2'b10);
        pin_in = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        wr(4'd7, 32'hFF, 2'b10);
        wr(4'd5, 32'hFF, 2'b10);
        pin_in = 8'hFF;
        repeat (4) @(posedge clk);
        #1;
        rd_chk("stat_all", 4'd7, 32'hFF);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rd_chk("stat_after_rst", 4'd7, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("irq_after_rst", 32'(irq), 32'h0);
        end

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            write_n  = (r < 3) ? 2'(r) : 2'b11;
            addr     = 4'($urandom_range(0, 15));
            data_in  = $urandom;
            read_n   = 2'($urandom_range(0, 3));
            pin_in   = pin_in ^ (NP'($urandom) & NP'($urandom));
            func_out = $urandom;
            func_oe  = $urandom;
            rst      = ($urandom_range(0, 499) == 0);
            @(posedge clk); #1;
        end

        rst = 1'b0;
        write_n = 2'b11;
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
